// File: rtl/dbuf2ddr_if.sv
// Bus bundle for dbuf2ddr: job control, 4-bank dbuf read port and DDR valid/ready stream.
// master = dbuf2ddr side, slave = environment side.
interface dbuf2ddr_if #(
  parameter int DATA_W = 8,
  parameter int BATCH  = 4,
  parameter int ADDR_W = 8
);
  localparam int DDR_W = DATA_W * BATCH;

  logic                   start;
  logic                   done;
  logic [2:0]             mode;
  logic [3:0]             ch_num;
  logic [3:0]             row_num;
  logic [3:0]             pix_num;
  logic [ADDR_W-1:0]      dbuf_rd_addr;
  logic [3:0]             dbuf_rd_en;
  logic [3:0][DDR_W-1:0]  dbuf_rd_data;
  logic [DDR_W-1:0]       ddr_data;
  logic                   ddr_valid;
  logic                   ddr_ready;

  modport master (
    input  start, mode, ch_num, row_num, pix_num, dbuf_rd_data, ddr_ready,
    output done, dbuf_rd_addr, dbuf_rd_en, ddr_data, ddr_valid
  );

  modport slave (
    output start, mode, ch_num, row_num, pix_num, dbuf_rd_data, ddr_ready,
    input  done, dbuf_rd_addr, dbuf_rd_en, ddr_data, ddr_valid
  );
endinterface

// File: rtl/dbuf2ddr.sv
// dbuf2ddr: reads dbuf banks in FC or CONV order into a 4-deep FIFO driving a valid/ready DDR stream.
// Optional macro DBUF2DDR_RELU_EN clamps negative DATA_W lanes to zero on FIFO entry.
module dbuf2ddr #(
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int DATA_W    = 8,
  parameter int BATCH     = 4,
  parameter int DDR_W     = DATA_W * BATCH
) (
  input  logic       clk,
  input  logic       rst,
  dbuf2ddr_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            r_state;
  logic              r_fc;
  logic [3:0]        r_ch_num, r_row_num, r_pix_num;
  logic [3:0]        r_ch_cnt, r_pix_cnt, r_row_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [3:0]        r_rd_en;
  logic [1:0]        r_rd_bank;
  logic              r_ret_vld;
  logic [1:0]        r_ret_bank;
  logic              r_done;
  logic [DDR_W-1:0]  r_fifo [4];
  logic [1:0]        r_wptr, r_rptr;
  logic [2:0]        r_cnt;

  logic              w_valid, w_pop, w_issue, w_last_rd, w_final;
  logic [2:0]        w_pending;
  logic [1:0]        w_bank;
  logic [ADDR_W-1:0] w_addr;
  logic [DDR_W-1:0]  w_raw, w_push_data;
  logic              w_unused_mode;

  assign w_unused_mode = ^bus.mode[2:1];

  assign w_valid   = (r_cnt != 3'd0);
  assign w_pop     = w_valid & bus.ddr_ready;
  // Credit check: FIFO words plus reads still in the 2-stage return path must leave room for one more.
  assign w_pending = r_cnt + {2'b00, |r_rd_en} + {2'b00, r_ret_vld};
  assign w_issue   = (r_state == RUN) && (w_pending <= 3'd3);

  assign w_bank    = r_fc ? 2'b00 : {r_row_cnt[0], r_pix_cnt[0]};
  assign w_addr    = r_fc ? ADDR_W'(r_ch_cnt)
                          : ADDR_W'({r_ch_cnt, r_row_cnt[1], r_pix_cnt[3:1]});
  assign w_last_rd = (r_ch_cnt == r_ch_num) &&
                     (r_fc || ((r_pix_cnt == r_pix_num) && (r_row_cnt == r_row_num)));
  assign w_final   = (r_state == DRAIN) && w_pop && (r_cnt == 3'd1) &&
                     !r_ret_vld && (r_rd_en == 4'd0);

  assign w_raw = bus.dbuf_rd_data[r_ret_bank];

  always_comb begin
    w_push_data = w_raw;
`ifdef DBUF2DDR_RELU_EN
    for (int unsigned i = 0; i < BATCH; i++)
      if (w_raw[i*DATA_W + DATA_W - 1]) w_push_data[i*DATA_W +: DATA_W] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_done     <= 1'b1;
      r_fc       <= 1'b0;
      r_ch_num   <= '0;
      r_row_num  <= '0;
      r_pix_num  <= '0;
      r_ch_cnt   <= '0;
      r_pix_cnt  <= '0;
      r_row_cnt  <= '0;
      r_rd_addr  <= '0;
      r_rd_en    <= '0;
      r_rd_bank  <= '0;
      r_ret_vld  <= 1'b0;
      r_ret_bank <= '0;
    end else begin
      r_rd_en    <= '0;
      r_ret_vld  <= |r_rd_en;
      r_ret_bank <= r_rd_bank;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_fc      <= bus.mode[0];
            r_ch_num  <= bus.ch_num;
            r_row_num <= bus.row_num;
            r_pix_num <= bus.pix_num;
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
            r_row_cnt <= '0;
            r_done    <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_issue) begin
            r_rd_en   <= 4'b0001 << w_bank;
            r_rd_addr <= w_addr;
            r_rd_bank <= w_bank;
            if (w_last_rd) begin
              r_state <= DRAIN;
            end else if (r_ch_cnt != r_ch_num) begin
              r_ch_cnt <= r_ch_cnt + 4'd1;
            end else begin
              // FC never reaches here: its last channel is also its last read.
              r_ch_cnt <= '0;
              if (r_pix_cnt != r_pix_num) begin
                r_pix_cnt <= r_pix_cnt + 4'd1;
              end else begin
                r_pix_cnt <= '0;
                r_row_cnt <= r_row_cnt + 4'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (w_final) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int unsigned i = 0; i < 4; i++) r_fifo[i] <= '0;
    end else begin
      if (r_ret_vld) begin
        r_fifo[r_wptr] <= w_push_data;
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      r_cnt <= r_cnt + {2'b00, r_ret_vld} - {2'b00, w_pop};
    end
  end

  assign bus.done         = r_done;
  assign bus.dbuf_rd_addr = r_rd_addr;
  assign bus.dbuf_rd_en   = r_rd_en;
  assign bus.ddr_valid    = w_valid;
  assign bus.ddr_data     = r_fifo[r_rptr];
endmodule

// File: tb/tb_dbuf2ddr.sv
// Scoreboard bench for dbuf2ddr: jobs push expected reads/beats computed from the read-order rules,
// an independent monitor pops and compares whenever the DUT issues a read or hands off a beat.
module tb_dbuf2ddr;
  localparam int DATA_W = 8;
  localparam int BATCH  = 4;
  localparam int DDR_W  = DATA_W * BATCH;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   job_id = 0;
  int   s_cyc = 0;
  int   ready_mode = 0;

  logic [DDR_W-1:0]  mem [4][256];
  logic [DDR_W-1:0]  exp_beats [$];
  logic [ADDR_W+3:0] exp_reads [$];

  int               issued, accepted, seen_job, rk;
  logic             stalled;
  logic [DDR_W-1:0] prev_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbuf2ddr_if #(.DATA_W(DATA_W), .BATCH(BATCH), .ADDR_W(ADDR_W)) bus ();

  dbuf2ddr #(.BUF_DEPTH(256), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BATCH(BATCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous banks: strobed banks return stored words, the others return noise.
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      bus.dbuf_rd_data[b] <= bus.dbuf_rd_en[b] ? mem[b][bus.dbuf_rd_addr] : DDR_W'($urandom);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DDR_W-1:0] model_word(input logic [DDR_W-1:0] w);
    logic [DDR_W-1:0] r;
    r = w;
`ifdef DBUF2DDR_RELU_EN
    for (int i = 0; i < BATCH; i++)
      if ($signed(w[i*DATA_W +: DATA_W]) < 0) r[i*DATA_W +: DATA_W] = '0;
`endif
    return r;
  endfunction

  task automatic fill_mem();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = DDR_W'($urandom);
  endtask

  task automatic post_job(input bit fc, input int ch, input int row, input int pix);
    int bank, addr;
    if (fc) begin
      for (int c = 0; c <= ch; c++) begin
        exp_reads.push_back({ADDR_W'(c), 4'b0001});
        exp_beats.push_back(model_word(mem[0][c]));
      end
    end else begin
      for (int r = 0; r <= row; r++)
        for (int p = 0; p <= pix; p++)
          for (int c = 0; c <= ch; c++) begin
            bank = (r % 2) * 2 + (p % 2);
            addr = c * 16 + ((r / 2) % 2) * 8 + p / 2;
            exp_reads.push_back({ADDR_W'(addr), 4'(1 << bank)});
            exp_beats.push_back(model_word(mem[bank][addr]));
          end
    end
  endtask

  task automatic run_job(input bit fc, input int ch, input int row, input int pix,
                         input int rmode, input int pulse_off, input bit refill);
    int n, s, k;
    n = fc ? ch + 1 : (ch + 1) * (row + 1) * (pix + 1);
    if (refill) fill_mem();
    @(posedge clk); #1;
    ready_mode = rmode;
    post_job(fc, ch, row, pix);
    bus.mode    = {2'($urandom), fc};
    bus.ch_num  = 4'(ch);
    bus.row_num = 4'(row);
    bus.pix_num = 4'(pix);
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s = cyc;
    s_cyc = s;
    job_id++;
    bus.mode    = 3'($urandom);
    bus.ch_num  = 4'($urandom);
    bus.row_num = 4'($urandom);
    bus.pix_num = 4'($urandom);
    @(negedge clk);
    chk("done_fall", 64'(bus.done), 64'(0));
    if (pulse_off > 0) begin
      repeat (pulse_off - 1) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    k = 0;
    @(negedge clk);
    while (!bus.done && k < n * 8 + 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 64'(bus.done), 64'(1));
    if (rmode == 0) chk("done_cycle", 64'(cyc - s), 64'(n + 3));
    chk("beats_remaining", 64'(exp_beats.size()), 64'(0));
    @(negedge clk);
    chk("done_holds", 64'(bus.done), 64'(1));
  endtask

  task automatic abort_job();
    fill_mem();
    @(posedge clk); #1;
    ready_mode = 0;
    post_job(1'b1, 15, 0, 0);
    bus.mode   = 3'b001;
    bus.ch_num = 4'd15;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    s_cyc = cyc;
    job_id++;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_done", 64'(bus.done), 64'(1));
    chk("abort_valid", 64'(bus.ddr_valid), 64'(0));
    chk("abort_rd_en", 64'(bus.dbuf_rd_en), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    rk = 0;
    bus.ddr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ddr_ready = 1'b1;
        1:       bus.ddr_ready = ((rk % 4) == 0) || ((rk % 4) == 3);
        default: bus.ddr_ready = 1'($urandom_range(0, 1));
      endcase
      rk++;
    end
  end

  initial begin
    issued = 0; accepted = 0; seen_job = 0; stalled = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_beats.delete();
        exp_reads.delete();
        issued   = 0;
        accepted = 0;
        stalled  = 1'b0;
      end else begin
        if (bus.dbuf_rd_en != 4'd0) begin
          chk("rd_en_while_idle", 64'(bus.done), 64'(0));
          chk("rd_outstanding_le3", 64'((issued - accepted) <= 3), 64'(1));
          chk("read_expected", 64'(exp_reads.size() != 0), 64'(1));
          if (exp_reads.size() != 0)
            chk("read_addr_bank", 64'({bus.dbuf_rd_addr, bus.dbuf_rd_en}), 64'(exp_reads.pop_front()));
          issued++;
        end
        if (stalled) begin
          chk("stall_valid_hold", 64'(bus.ddr_valid), 64'(1));
          chk("stall_data_hold", 64'(bus.ddr_data), 64'(prev_data));
        end
        if (bus.ddr_valid && seen_job != job_id) begin
          seen_job = job_id;
          chk("first_valid_latency", 64'(cyc - s_cyc), 64'(3));
        end
        if (bus.ddr_valid && bus.ddr_ready) begin
          chk("beat_expected", 64'(exp_beats.size() != 0), 64'(1));
          if (exp_beats.size() != 0)
            chk("beat_data", 64'(bus.ddr_data), 64'(exp_beats.pop_front()));
          accepted++;
        end
        stalled   = bus.ddr_valid && !bus.ddr_ready;
        prev_data = bus.ddr_data;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.mode = '0; bus.ch_num = '0; bus.row_num = '0; bus.pix_num = '0;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 64'(bus.done), 64'(1));
    chk("rst_valid", 64'(bus.ddr_valid), 64'(0));
    chk("rst_rd_en", 64'(bus.dbuf_rd_en), 64'(0));
    chk("rst_rd_addr", 64'(bus.dbuf_rd_addr), 64'(0));
    chk("rst_ddr_data", 64'(bus.ddr_data), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    run_job(1'b1, 3, 0, 0, 0, 0, 1'b1);
    run_job(1'b0, 1, 1, 1, 0, 0, 1'b1);
    run_job(1'b0, 0, 3, 3, 1, 0, 1'b1);
    run_job(1'b1, 15, 0, 0, 0, 5, 1'b1);
    run_job(1'b0, 3, 2, 2, 2, 7, 1'b1);
    run_job(1'b0, 2, 1, 1, 0, 15, 1'b1);
    abort_job();
    run_job(1'b1, 15, 0, 0, 0, 0, 1'b1);

    fill_mem();
    mem[0][0] = {8'($urandom), 8'($urandom), 8'h07, 8'hFB};
    run_job(1'b1, 0, 0, 0, 0, 0, 1'b0);

    for (int j = 0; j < 24; j++)
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dbuf2ddr.md
DBUF2DDR -- requirements
Module: dbuf2ddr

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- BUF_DEPTH, 256, words per dbuf bank.
- ADDR_W, bw(BUF_DEPTH), dbuf address width.
- DATA_W, BATCH, DDR_W from GLOBAL_PARAM, with DDR_W = DATA_W*BATCH.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle job launch.
- done, out, 1, idle/complete flag.
- mode, in, 3, bit0: 1=FC, 0=CONV.
- ch_num, in, 4, channels-1.
- row_num, in, 4, rows-1 (CONV only).
- pix_num, in, 4, pixels per row-1 (CONV only).
- dbuf_rd_addr, out, ADDR_W, bank read address.
- dbuf_rd_en, out, 4, per-bank read strobe.
- dbuf_rd_data, in, [3:0][DATA_W*BATCH], bank read data, valid exactly 1 cycle after dbuf_rd_en.
- ddr_data, out, DDR_W, stream data.
- ddr_valid, out, 1, stream valid.
- ddr_ready, in, 1, stream ready.

REQ-003 One clock (clk); reset rst SHALL be synchronous and active-high.

Function
REQ-004 mode, ch_num, row_num, pix_num SHALL be latched on start when the block is in IDLE; start outside IDLE SHALL be ignored.

REQ-005 FSM states SHALL be IDLE, RUN and DRAIN:
- IDLE->RUN on start.
- RUN->DRAIN in the cycle the last read is issued.
- DRAIN->IDLE when the last beat handshakes (ddr_valid&&ddr_ready).

REQ-006 CONV read order SHALL be channel innermost, then pixel, then row. Each read beat SHALL use:
- address = {ch_cnt, row_cnt[1], pix_cnt[3:1]}, with ch_cnt zero-extended into ADDR_W-1:4;
- one-hot bank = 1<<{row_cnt[0], pix_cnt[0]}.

REQ-007 CONV SHALL emit exactly (ch_num+1)*(pix_num+1)*(row_num+1) beats.

REQ-008 FC SHALL read bank 0 only (dbuf_rd_en=4'b0001), addresses 0..ch_num, emitting ch_num+1 beats.

REQ-009 The returned data SHALL be selected from the bank whose strobe was issued one cycle earlier. That bank index SHALL be carried with the read.

REQ-010 Returned data SHALL enter a 4-entry output FIFO whose head drives ddr_data/ddr_valid.

REQ-011 A read SHALL be issued only when FIFO occupancy + in-flight reads <= 3, so no returned word is ever dropped.

REQ-012 While ddr_valid=1 and ddr_ready=0, ddr_data and ddr_valid SHALL hold stable.

REQ-013 With ddr_ready held at 1, the first ddr_valid SHALL rise 3 cycles after start and the block SHALL sustain 1 beat per cycle with no bubbles.

REQ-014 Beats SHALL leave the block in read order; no beat SHALL be duplicated or skipped.

REQ-015 Counters SHALL wrap as follows:
- ch_cnt wraps ch_num->0, advancing pix_cnt;
- pix_cnt wraps pix_num->0, advancing row_cnt;
- row_cnt does not wrap within a job.

REQ-016 done SHALL:
- fall the cycle after an accepted start;
- rise the cycle after the final beat handshakes;
- stay high in IDLE.

REQ-017 A start coinciding with the final handshake SHALL be ignored; done SHALL still rise.

REQ-018 dbuf_rd_en SHALL be 0 in IDLE and whenever no read is issued.

Reset
REQ-019 On rst, state SHALL go to IDLE and all counters and the FIFO SHALL clear. Output reset values: done=1, ddr_valid=0, dbuf_rd_en=0, dbuf_rd_addr=0, ddr_data=0.

REQ-020 A rst asserted mid-job SHALL abort the job; in-flight read data returning the next cycle SHALL be discarded.

Configuration
REQ-021 With DBUF2DDR_RELU_EN defined, each DATA_W signed lane of ddr_data SHALL be replaced by 0 if negative, applied at the FIFO input with no added latency.

REQ-022 Without DBUF2DDR_RELU_EN, data SHALL pass bit-exact.

Verification
REQ-023 FC, ch_num=3, ddr_ready=1: expect reads at addresses 0,1,2,3 on bank 0; 4 beats from start+3 on consecutive cycles; done high at start+7.

REQ-024 CONV, ch_num=1, pix_num=1, row_num=1: expect 8 beats. The first four reads (with their banks) SHALL be:
- addr 0x00, bank 0001;
- addr 0x10, bank 0001;
- addr 0x00, bank 0010;
- addr 0x10, bank 0010.

REQ-025 CONV, ch_num=0, pix_num=3, row_num=3, with ddr_ready toggling 1,0,0,1 repeatedly: expect 16 beats in order, data stable during stalls, dbuf_rd_en never issued with 4 words outstanding.

REQ-026 rst asserted 5 cycles into an FC ch_num=15 job: expect done=1, ddr_valid=0 next cycle. A new start then runs a clean, full-length job.

REQ-027 start pulsed while done=0: expect no change in beat count or order of the running job.

REQ-028 With DBUF2DDR_RELU_EN, a dbuf word whose lanes are -5 and 7: expect ddr_data lanes 0 and 7; without the macro expect -5 and 7.
